mod_updown_counter: RTL and testbench

Parametrised successor to the fixed 4-bit upcounter: a WIDTH-bit modulo-N counter with up/down mode, synchronous parallel load, count enable, and selectable wrap or saturate at the range limits. It provides terminal-count, wrap-event and sticky overflow status. It is the general counter primitive for timers, address generators and event counters in the sequential library.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/mod_updown_counter_prescaler.sv | 36 +++
 rtl/mod_updown_counter.sv | 93 +++++++++
 tb/tb_mod_updown_counter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg: shared constants and sizing helper for the counter library.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  localparam int LIMIT_WRAP = 0;
  localparam int LIMIT_SAT  = 0 + 1;

  function automatic int clog2(input int unsigned n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_updown_counter_prescaler.sv
// ---------------------------------------------------------------------------
// count_prescaler: emits tick on every PRESCALE-th enabled cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module count_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // A 1-bit counter still works for PRESCALE=1: it never leaves zero.
  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_updown_counter.sv
// ---------------------------------------------------------------------------
// mod_updown_counter: WIDTH-bit modulo-MODULUS up/down counter, wrap or
// saturate. Optional prescaler: define COUNTER_PRESCALE_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (!(WIDTH >= 1 && MODULUS >= 2 && longint'(MODULUS) <= (longint'(1) << WIDTH)
        && PRESCALE >= 1)) begin : g_param_check
    $error("mod_updown_counter: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;
  logic             at_limit;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] limit_val;
  logic [WIDTH-1:0] load_val;
  logic             step;

  // Up limit is detected as count+1 reaching MODULUS, down limit as a borrow.
  assign inc      = {1'b0, count} + (WIDTH + 1)'(1);
  assign dec      = {1'b0, count} - (WIDTH + 1)'(1);
  assign at_limit = (up == CNT_UP) ? (inc == MOD_X) : dec[WIDTH];
  assign tc       = at_limit;

  assign step_val  = (up == CNT_UP) ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
  assign limit_val = (SATURATE == LIMIT_SAT) ? count : ((up == CNT_UP) ? '0 : MAX_V);
  assign load_val  = ({1'b0, d_in} >= MOD_X) ? MAX_V : d_in;

`ifdef COUNTER_PRESCALE_EN
  logic tick;

  count_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .clr  (clr | ld),
    .en   (en & ~ld),
    .tick (tick)
  );

  assign step = tick;
`else
  assign step = en & ~ld;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (ld) begin
      count <= load_val;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (step && at_limit) begin
      count <= limit_val;
      wrap  <= 1'b1;
      ovf   <= 1'b1;
    end else if (step) begin
      count <= step_val;
      wrap  <= 1'b0;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_updown_counter: directed bench for wrap, saturate and prescale builds.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       clr, ld, en, up;
  logic [3:0] d_in;
  logic [3:0] count_w, count_s, count_p;
  logic       tc_w, wrap_w, ovf_w;
  logic       tc_s, wrap_s, ovf_s;
  logic       tc_p, wrap_p, ovf_p;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .clr(clr), .ld(ld), .en(en), .up(up), .d_in(d_in),
    .count(count_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .clr(clr), .ld(ld), .en(en), .up(up), .d_in(d_in),
    .count(count_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(4)) u_pre (
    .clk(clk), .clr(clr), .ld(ld), .en(en), .up(up), .d_in(d_in),
    .count(count_p), .tc(tc_p), .wrap(wrap_p), .ovf(ovf_p));

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1; ld = 0; en = 0; up = 1; d_in = 4'd0;
    cycle();
    vectors++; if (count_w !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_w); end
    vectors++; if (wrap_w !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap_w); end
    vectors++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_w); end
    vectors++; if (count_s !== 4'd0) begin errors++; $display("FAIL reset_count_sat got=%0d exp=0", count_s); end
    vectors++; if (tc_w !== 1'b0) begin errors++; $display("FAIL reset_tc_up got=%b exp=0", tc_w); end
    up = 0;
    #1;
    vectors++; if (tc_w !== 1'b1) begin errors++; $display("FAIL reset_tc_down got=%b exp=1", tc_w); end
    clr = 0; up = 1;
  endtask

  task automatic test_up_wrap();
    logic [3:0] e [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    clr = 1; cycle(); clr = 0;
    up = 1; en = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      vectors++; if (count_w !== e[i]) begin errors++; $display("FAIL up_count[%0d] got=%0d exp=%0d", i, count_w, e[i]); end
      vectors++; if (wrap_w !== (i == 9)) begin errors++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap_w, (i == 9)); end
      vectors++; if (ovf_w !== (i >= 9)) begin errors++; $display("FAIL up_ovf[%0d] got=%b exp=%b", i, ovf_w, (i >= 9)); end
      vectors++; if (tc_w !== (e[i] == 4'd9)) begin errors++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, tc_w, (e[i] == 4'd9)); end
    end
    en = 0;
    cycle();
    vectors++; if (count_w !== 4'd2) begin errors++; $display("FAIL up_hold got=%0d exp=2", count_w); end
    vectors++; if (wrap_w !== 1'b0) begin errors++; $display("FAIL up_hold_wrap got=%b exp=0", wrap_w); end
  endtask

  task automatic test_down_load();
    logic [3:0] ew [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    logic [3:0] es [5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    ld = 1; d_in = 4'd3; en = 0;
    cycle(); ld = 0;
    vectors++; if (count_w !== 4'd3) begin errors++; $display("FAIL load3_count got=%0d exp=3", count_w); end
    vectors++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL load3_ovf got=%b exp=0", ovf_w); end
    up = 0; en = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      vectors++; if (count_w !== ew[i]) begin errors++; $display("FAIL dn_count[%0d] got=%0d exp=%0d", i, count_w, ew[i]); end
      vectors++; if (wrap_w !== (i == 3)) begin errors++; $display("FAIL dn_wrap[%0d] got=%b exp=%b", i, wrap_w, (i == 3)); end
      vectors++; if (ovf_w !== (i >= 3)) begin errors++; $display("FAIL dn_ovf[%0d] got=%b exp=%b", i, ovf_w, (i >= 3)); end
      vectors++; if (tc_w !== (ew[i] == 4'd0)) begin errors++; $display("FAIL dn_tc[%0d] got=%b exp=%b", i, tc_w, (ew[i] == 4'd0)); end
      vectors++; if (count_s !== es[i]) begin errors++; $display("FAIL dn_sat_count[%0d] got=%0d exp=%0d", i, count_s, es[i]); end
    end
    en = 0;
  endtask

  task automatic test_saturate();
    ld = 1; d_in = 4'd8; en = 0;
    cycle(); ld = 0;
    vectors++; if (count_s !== 4'd8) begin errors++; $display("FAIL sat_load got=%0d exp=8", count_s); end
    vectors++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL sat_load_ovf got=%b exp=0", ovf_s); end
    up = 1; en = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++; if (count_s !== 4'd9) begin errors++; $display("FAIL sat_count[%0d] got=%0d exp=9", i, count_s); end
      vectors++; if (wrap_s !== (i >= 1)) begin errors++; $display("FAIL sat_wrap[%0d] got=%b exp=%b", i, wrap_s, (i >= 1)); end
      vectors++; if (ovf_s !== (i >= 1)) begin errors++; $display("FAIL sat_ovf[%0d] got=%b exp=%b", i, ovf_s, (i >= 1)); end
      vectors++; if (tc_s !== 1'b1) begin errors++; $display("FAIL sat_tc[%0d] got=%b exp=1", i, tc_s); end
    end
    vectors++; if (count_w !== 4'd2) begin errors++; $display("FAIL sat_wrapinst got=%0d exp=2", count_w); end
    en = 0;
    cycle();
    vectors++; if (wrap_s !== 1'b0) begin errors++; $display("FAIL sat_idle_wrap got=%b exp=0", wrap_s); end
    vectors++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL sat_sticky_ovf got=%b exp=1", ovf_s); end
  endtask

  task automatic test_load_priority();
    ld = 1; en = 0; d_in = 4'd14;
    cycle();
    vectors++; if (count_w !== 4'd9) begin errors++; $display("FAIL load14 got=%0d exp=9", count_w); end
    d_in = 4'd10;
    cycle();
    vectors++; if (count_w !== 4'd9) begin errors++; $display("FAIL load10 got=%0d exp=9", count_w); end
    d_in = 4'd2; en = 1; up = 1;
    cycle();
    vectors++; if (count_w !== 4'd2) begin errors++; $display("FAIL load_over_en got=%0d exp=2", count_w); end
    vectors++; if (wrap_w !== 1'b0) begin errors++; $display("FAIL load_over_en_wrap got=%b exp=0", wrap_w); end
    clr = 1; d_in = 4'd5;
    cycle();
    vectors++; if (count_w !== 4'd0) begin errors++; $display("FAIL clr_over_ld got=%0d exp=0", count_w); end
    clr = 0; ld = 0; en = 0;
  endtask

  task automatic test_reset_mid();
    clr = 1; cycle(); clr = 0;
    up = 0; en = 1;
    cycle();
    vectors++; if (count_w !== 4'd9 || ovf_w !== 1'b1) begin errors++; $display("FAIL mid_underflow got=%0d/%b exp=9/1", count_w, ovf_w); end
    for (int i = 0; i < 3; i++) cycle();
    vectors++; if (count_w !== 4'd6) begin errors++; $display("FAIL mid_count got=%0d exp=6", count_w); end
    up = 1; clr = 1;
    cycle();
    vectors++; if (count_w !== 4'd0) begin errors++; $display("FAIL mid_clr_count got=%0d exp=0", count_w); end
    vectors++; if (ovf_w !== 1'b0) begin errors++; $display("FAIL mid_clr_ovf got=%b exp=0", ovf_w); end
    vectors++; if (wrap_w !== 1'b0) begin errors++; $display("FAIL mid_clr_wrap got=%b exp=0", wrap_w); end
    clr = 0;
    cycle();
    vectors++; if (count_w !== 4'd1) begin errors++; $display("FAIL mid_resume got=%0d exp=1", count_w); end
    en = 0;
  endtask

  task automatic test_prescale();
    bit en_p [22] = '{1,1,1,1,1,1,1,1, 1,1, 0,0,0, 1,1, 1,1, 1, 1,1,1,1};
    bit ld_p [22] = '{0,0,0,0,0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 1, 0,0,0,0};
`ifdef COUNTER_PRESCALE_EN
    logic [3:0] e [22] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2,
                           4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6};
`else
    logic [3:0] e [22] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd0,
                           4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
`endif
    clr = 1; en = 0; ld = 0; cycle(); clr = 0;
    up = 1; d_in = 4'd5;
    for (int i = 0; i < 22; i++) begin
      en = en_p[i]; ld = ld_p[i];
      cycle();
      vectors++; if (count_p !== e[i]) begin errors++; $display("FAIL presc_count[%0d] got=%0d exp=%0d", i, count_p, e[i]); end
    end
    en = 0; ld = 0;
  endtask

  initial begin
    clr = 1; ld = 0; en = 0; up = 1; d_in = 4'd0;
    test_reset();
    test_up_wrap();
    test_down_load();
    test_saturate();
    test_load_priority();
    test_reset_mid();
    test_prescale();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
